kamacore_stage_wb: RTL and testbench
====================================

// Module: kamacore_stage_wb
// PURPOSE
// Writeback stage: accepts completed results from the memory stage over a valid/ready
// handshake and buffers them in a small in-order FIFO. It aligns and extends load data,
// then drives the single register-file write port (writeback_rd_we/_a/_data) that the
// decode stage's register file consumes. It also exposes a pending-write query so decode
// can detect RAW hazards on results not yet written.
// PARAMETERS
// CPU_WIDTH       32  datapath width; load alignment logic is defined for 32 only
// REG_ADDR_WIDTH  5   register address width
// DEPTH           2   FIFO entries; power of two, >=2
// PORTS
// clk                 in   1               clock; all state updates on posedge
// rst                 in   1               synchronous reset, active-low
// mem_valid           in   1               memory stage presents a result
// mem_ready           out  1               stage can accept; high when count != DEPTH
// mem_rd_we           in   1               instruction writes rd
// mem_rd_a            in   REG_ADDR_WIDTH  destination register
// mem_is_load         in   1               result comes from memory read data
// mem_funct3          in   3               load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
// mem_result          in   CPU_WIDTH       ALU result; the effective address for loads
// mem_load_word       in   CPU_WIDTH       aligned 32-bit word read from memory
// wb_stall            in   1               write port blocked this cycle; hold the FIFO head
// writeback_rd_we     out  1               register-file write enable
// writeback_rd_a      out  REG_ADDR_WIDTH  register-file write address
// writeback_rd_data   out  CPU_WIDTH       register-file write data
// query_a             in   REG_ADDR_WIDTH  decode source register to check
// query_hit           out  1               a buffered entry will still write query_a
// load_err            out  1               one-cycle pulse: misaligned or illegal load accepted
// retired             out  32              count of entries popped
// BEHAVIOUR
// - Reset: FIFO empty, count=0, load_err=0, retired=0.
//   Reset asserted mid-operation discards all buffered entries.
// - Reset outputs: writeback_rd_we=0, writeback_rd_a=0, writeback_rd_data=0, mem_ready=1.
// - Push: on posedge when mem_valid && mem_ready. mem_ready depends only on count,
//   never on the same-cycle pop, so there is no combinational path wb_stall->mem_ready.
// - Pop: on posedge when FIFO non-empty && !wb_stall.
//   Push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
// - Write-port outputs are combinational from the FIFO head.
//   writeback_rd_we = !empty && head.we && !wb_stall.
//   When the FIFO is empty, _a and _data drive 0.
// - Latency: an entry pushed at edge N drives the write port in the cycle after N,
//   if it is at the head and wb_stall=0. In-order only.
// - Load data is computed at push time and stored, using byte offset off = mem_result[1:0]:
//   LB/LBU selects byte[off], sign- or zero-extended to 32 bits.
//   LH/LHU selects halfword[off[1]], sign- or zero-extended to 32 bits.
//   LW selects the whole word.
// - Non-load entries store mem_result unchanged.
// - Misaligned load: LH/LHU with off[0]=1, or LW with off!=0.
// - Illegal load: funct3 in {011, 110, 111} with mem_is_load=1.
// - On a misaligned or illegal load the entry is still pushed (preserves order and retire
//   count) but with we=0. load_err is registered high for exactly one cycle after the push.
// - rd_a==0: the stored we is forced to 0. The entry still occupies the FIFO and is counted.
// - query_hit (combinational): 1 iff query_a != 0 and any valid entry has we=1 and
//   rd_a==query_a. Includes the head during a cycle it is being written.
// - retired increments by 1 on each pop, regardless of we, and wraps 2^32-1 -> 0.
// TESTING
// - ALU result: push rd=5, data=0xDEADBEEF, wb_stall=0 -> next cycle we=1, a=5,
//   data=0xDEADBEEF; retired=1.
// - Loads on word 0x8081F2F3:
//   LB off=1 -> 0xFFFFFFF2; LBU off=3 -> 0x00000080; LH off=2 -> 0xFFFF8081;
//   LHU off=0 -> 0x0000F2F3; LW off=0 -> 0x8081F2F3.
// - Backpressure: hold wb_stall=1 and push 3 times.
//   -> mem_ready drops after 2 pushes, we stays 0, query_hit=1 for both rds.
//   Release wb_stall -> entries written in order over 2 cycles.
// - Errors: LW at addr 0x...2 and funct3=011 load -> load_err pulses 1 cycle each,
//   no register write, retired still increments.
// - rd=x0: push rd=0, data=0x1234 -> we stays 0; query_a=0 -> query_hit=0.
// - Reset mid-op: with 2 entries buffered, assert rst for 1 cycle -> count=0, we=0,
//   mem_ready=1, retired=0.

Source files
------------

// File: rtl/kamacore_stage_wb.sv
// Writeback stage: in-order result FIFO between memory stage and register-file write port.
// Load data is aligned/extended at push time; head entry drives the write port combinationally.
module kamacore_stage_wb #(
    parameter int CPU_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic                      mem_rd_we,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_a,
    input  logic                      mem_is_load,
    input  logic [2:0]                mem_funct3,
    input  logic [CPU_WIDTH-1:0]      mem_result,
    input  logic [CPU_WIDTH-1:0]      mem_load_word,
    input  logic                      wb_stall,
    output logic                      writeback_rd_we,
    output logic [REG_ADDR_WIDTH-1:0] writeback_rd_a,
    output logic [CPU_WIDTH-1:0]      writeback_rd_data,
    input  logic [REG_ADDR_WIDTH-1:0] query_a,
    output logic                      query_hit,
    output logic                      load_err,
    output logic [31:0]               retired
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic                      r_we   [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] r_a    [DEPTH];
    logic [CPU_WIDTH-1:0]      r_data [DEPTH];
    logic [DEPTH-1:0]          r_vld;
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_count;
    logic                      r_load_err;
    logic [31:0]               r_retired;

    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic [1:0]                w_off;
    logic [7:0]                w_byte;
    logic [15:0]               w_half;
    logic [CPU_WIDTH-1:0]      w_ext;
    logic                      w_misaligned;
    logic                      w_illegal;
    logic                      w_bad_load;
    logic                      w_store_we;
    logic [CPU_WIDTH-1:0]      w_store_data;

    assign w_empty   = (r_count == '0);
    assign mem_ready = (r_count != FULL_CNT);
    assign w_push    = mem_valid && mem_ready;
    assign w_pop     = !w_empty && !wb_stall;

    // Load alignment: funct3[1:0] selects size, funct3[2] selects zero-extension.
    always_comb begin
        w_off  = mem_result[1:0];
        w_byte = mem_load_word[{w_off, 3'b000} +: 8];
        w_half = mem_load_word[{w_off[1], 4'b0000} +: 16];
        case (mem_funct3[1:0])
            2'b00:   w_ext = mem_funct3[2] ? {{(CPU_WIDTH-8){1'b0}}, w_byte}
                                           : {{(CPU_WIDTH-8){w_byte[7]}}, w_byte};
            2'b01:   w_ext = mem_funct3[2] ? {{(CPU_WIDTH-16){1'b0}}, w_half}
                                           : {{(CPU_WIDTH-16){w_half[15]}}, w_half};
            default: w_ext = mem_load_word;
        endcase
        w_illegal    = (mem_funct3 == 3'b011) || (mem_funct3 == 3'b110) ||
                       (mem_funct3 == 3'b111);
        w_misaligned = ((mem_funct3[1:0] == 2'b01) && w_off[0]) ||
                       ((mem_funct3 == 3'b010) && (w_off != 2'b00));
        w_bad_load   = mem_is_load && (w_illegal || w_misaligned);
        w_store_we   = mem_rd_we && (mem_rd_a != '0) && !w_bad_load;
        w_store_data = mem_is_load ? w_ext : mem_result;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_load_err <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_load_err <= w_push && w_bad_load;
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
                r_retired       <= r_retired + 32'd1;
            end
            if (w_push) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: r_vld and r_count gate every use of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_we[r_wr_ptr]   <= w_store_we;
            r_a[r_wr_ptr]    <= mem_rd_a;
            r_data[r_wr_ptr] <= w_store_data;
        end
    end

    always_comb begin
        writeback_rd_we   = 1'b0;
        writeback_rd_a    = '0;
        writeback_rd_data = '0;
        if (!w_empty) begin
            writeback_rd_we   = r_we[r_rd_ptr] && !wb_stall;
            writeback_rd_a    = r_a[r_rd_ptr];
            writeback_rd_data = r_data[r_rd_ptr];
        end
    end

    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && r_we[i] && (r_a[i] == query_a) && (query_a != '0))
                query_hit = 1'b1;
        end
    end

    assign load_err = r_load_err;
    assign retired  = r_retired;

endmodule

// File: tb/tb_kamacore_stage_wb.sv
// Directed self-checking bench for kamacore_stage_wb: handshake, load alignment,
// backpressure, error pulses, x0 handling and mid-operation reset.
module tb_kamacore_stage_wb;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_rd_we;
    logic [4:0]  mem_rd_a;
    logic        mem_is_load;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_result;
    logic [31:0] mem_load_word;
    logic        wb_stall;
    logic        writeback_rd_we;
    logic [4:0]  writeback_rd_a;
    logic [31:0] writeback_rd_data;
    logic [4:0]  query_a;
    logic        query_hit;
    logic        load_err;
    logic [31:0] retired;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_ret = 0;

    kamacore_stage_wb #(.CPU_WIDTH(32), .REG_ADDR_WIDTH(5), .DEPTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .mem_rd_we         (mem_rd_we),
        .mem_rd_a          (mem_rd_a),
        .mem_is_load       (mem_is_load),
        .mem_funct3        (mem_funct3),
        .mem_result        (mem_result),
        .mem_load_word     (mem_load_word),
        .wb_stall          (wb_stall),
        .writeback_rd_we   (writeback_rd_we),
        .writeback_rd_a    (writeback_rd_a),
        .writeback_rd_data (writeback_rd_data),
        .query_a           (query_a),
        .query_hit         (query_hit),
        .load_err          (load_err),
        .retired           (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] a, input logic ld,
                         input logic [2:0] f3, input logic [31:0] res,
                         input logic [31:0] word);
        mem_valid     = 1'b1;
        mem_rd_we     = we;
        mem_rd_a      = a;
        mem_is_load   = ld;
        mem_funct3    = f3;
        mem_result    = res;
        mem_load_word = word;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        query_a = 5'd5;
        #1;
        checks++;
        if (writeback_rd_we !== 1'b0 || writeback_rd_a !== 5'd0 || writeback_rd_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_wport got we=%0b a=%0d d=%h want we=0 a=0 d=0",
                     writeback_rd_we, writeback_rd_a, writeback_rd_data);
        end
        checks++;
        if (mem_ready !== 1'b1 || retired !== 32'd0 || load_err !== 1'b0 || query_hit !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got ready=%0b ret=%0d err=%0b hit=%0b want 1 0 0 0",
                     mem_ready, retired, load_err, query_hit);
        end
    endtask

    task automatic test_alu();
        wb_stall = 1'b0;
        drive(1'b1, 5'd5, 1'b0, 3'b000, 32'hDEADBEEF, 32'h0);
        tick();
        mem_valid = 1'b0;
        query_a = 5'd5;
        #1;
        checks++;
        if (writeback_rd_we !== 1'b1 || writeback_rd_a !== 5'd5 ||
            writeback_rd_data !== 32'hDEADBEEF || query_hit !== 1'b1) begin
            failures++;
            $display("FAIL alu_write got we=%0b a=%0d d=%h hit=%0b want 1 5 deadbeef 1",
                     writeback_rd_we, writeback_rd_a, writeback_rd_data, query_hit);
        end
        tick();
        exp_ret = exp_ret + 1;
        checks++;
        if (retired !== exp_ret || writeback_rd_we !== 1'b0) begin
            failures++;
            $display("FAIL alu_retire got ret=%0d we=%0b want ret=%0d we=0",
                     retired, writeback_rd_we, exp_ret);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] adr [5] = '{32'h1001, 32'h1003, 32'h1002, 32'h1000, 32'h1000};
        logic [31:0] exp [5] = '{32'hFFFFFFF2, 32'h00000080, 32'hFFFF8081,
                                 32'h0000F2F3, 32'h8081F2F3};
        wb_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(10 + i), 1'b1, f3[i], adr[i], 32'h8081F2F3);
            tick();
            mem_valid = 1'b0;
            #1;
            checks++;
            if (writeback_rd_we !== 1'b1 || writeback_rd_a !== 5'(10 + i) ||
                writeback_rd_data !== exp[i] || load_err !== 1'b0) begin
                failures++;
                $display("FAIL load_%0d got we=%0b a=%0d d=%h err=%0b want 1 %0d %h 0",
                         i, writeback_rd_we, writeback_rd_a, writeback_rd_data, load_err,
                         10 + i, exp[i]);
            end
            tick();
            exp_ret = exp_ret + 1;
        end
        checks++;
        if (retired !== exp_ret) begin
            failures++;
            $display("FAIL load_retired got %0d want %0d", retired, exp_ret);
        end
    endtask

    task automatic test_back_to_back();
        wb_stall = 1'b0;
        drive(1'b1, 5'd1, 1'b0, 3'b000, 32'h11, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i < 3) drive(1'b1, 5'(i + 1), 1'b0, 3'b000, 32'(17 * (i + 1)), 32'h0);
            else       mem_valid = 1'b0;
            #1;
            checks++;
            if (writeback_rd_we !== 1'b1 || writeback_rd_a !== 5'(i) ||
                writeback_rd_data !== 32'(17 * i) || mem_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_%0d got we=%0b a=%0d d=%h rdy=%0b want 1 %0d %h 1",
                         i, writeback_rd_we, writeback_rd_a, writeback_rd_data, mem_ready,
                         i, 17 * i);
            end
        end
        tick();
        exp_ret = exp_ret + 3;
        checks++;
        if (retired !== exp_ret || writeback_rd_we !== 1'b0) begin
            failures++;
            $display("FAIL b2b_retired got ret=%0d we=%0b want ret=%0d we=0",
                     retired, writeback_rd_we, exp_ret);
        end
    endtask

    task automatic test_backpressure();
        wb_stall = 1'b1;
        drive(1'b1, 5'd7, 1'b0, 3'b000, 32'h70, 32'h0);
        tick();
        drive(1'b1, 5'd8, 1'b0, 3'b000, 32'h80, 32'h0);
        #1;
        checks++;
        if (mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_one got %0b want 1", mem_ready);
        end
        tick();
        drive(1'b1, 5'd9, 1'b0, 3'b000, 32'h90, 32'h0);
        #1;
        checks++;
        if (mem_ready !== 1'b0 || writeback_rd_we !== 1'b0) begin
            failures++;
            $display("FAIL bp_full got ready=%0b we=%0b want 0 0", mem_ready, writeback_rd_we);
        end
        query_a = 5'd7; #1;
        checks++;
        if (query_hit !== 1'b1) begin
            failures++;
            $display("FAIL bp_hit7 got %0b want 1", query_hit);
        end
        query_a = 5'd8; #1;
        checks++;
        if (query_hit !== 1'b1) begin
            failures++;
            $display("FAIL bp_hit8 got %0b want 1", query_hit);
        end
        query_a = 5'd9; #1;
        checks++;
        if (query_hit !== 1'b0) begin
            failures++;
            $display("FAIL bp_hit9 got %0b want 0", query_hit);
        end
        tick();
        mem_valid = 1'b0;
        wb_stall  = 1'b0;
        #1;
        checks++;
        if (writeback_rd_we !== 1'b1 || writeback_rd_a !== 5'd7 || writeback_rd_data !== 32'h70) begin
            failures++;
            $display("FAIL bp_first got we=%0b a=%0d d=%h want 1 7 70",
                     writeback_rd_we, writeback_rd_a, writeback_rd_data);
        end
        tick(); #1;
        checks++;
        if (writeback_rd_we !== 1'b1 || writeback_rd_a !== 5'd8 ||
            writeback_rd_data !== 32'h80 || mem_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_second got we=%0b a=%0d d=%h rdy=%0b want 1 8 80 1",
                     writeback_rd_we, writeback_rd_a, writeback_rd_data, mem_ready);
        end
        tick();
        exp_ret = exp_ret + 2;
        checks++;
        if (retired !== exp_ret || writeback_rd_we !== 1'b0) begin
            failures++;
            $display("FAIL bp_retired got ret=%0d we=%0b want ret=%0d we=0",
                     retired, writeback_rd_we, exp_ret);
        end
    endtask

    task automatic test_errors();
        logic [2:0]  f3  [2] = '{3'b010, 3'b011};
        logic [31:0] adr [2] = '{32'h1002, 32'h1000};
        wb_stall = 1'b0;
        query_a  = 5'd3;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd3, 1'b1, f3[i], adr[i], 32'h8081F2F3);
            tick();
            mem_valid = 1'b0;
            #1;
            checks++;
            if (load_err !== 1'b1 || writeback_rd_we !== 1'b0 || query_hit !== 1'b0) begin
                failures++;
                $display("FAIL err_%0d_pulse got err=%0b we=%0b hit=%0b want 1 0 0",
                         i, load_err, writeback_rd_we, query_hit);
            end
            tick();
            exp_ret = exp_ret + 1;
            checks++;
            if (load_err !== 1'b0 || retired !== exp_ret) begin
                failures++;
                $display("FAIL err_%0d_after got err=%0b ret=%0d want 0 %0d",
                         i, load_err, retired, exp_ret);
            end
        end
    endtask

    task automatic test_x0();
        wb_stall = 1'b0;
        query_a  = 5'd0;
        drive(1'b1, 5'd0, 1'b0, 3'b000, 32'h1234, 32'h0);
        tick();
        mem_valid = 1'b0;
        #1;
        checks++;
        if (writeback_rd_we !== 1'b0 || query_hit !== 1'b0 || writeback_rd_data !== 32'h1234) begin
            failures++;
            $display("FAIL x0 got we=%0b hit=%0b d=%h want 0 0 1234",
                     writeback_rd_we, query_hit, writeback_rd_data);
        end
        tick();
        exp_ret = exp_ret + 1;
        checks++;
        if (retired !== exp_ret) begin
            failures++;
            $display("FAIL x0_retired got %0d want %0d", retired, exp_ret);
        end
    endtask

    task automatic test_reset_midop();
        wb_stall = 1'b1;
        drive(1'b1, 5'd4, 1'b0, 3'b000, 32'h44, 32'h0);
        tick();
        drive(1'b1, 5'd6, 1'b0, 3'b000, 32'h66, 32'h0);
        tick();
        mem_valid = 1'b0;
        #1;
        checks++;
        if (mem_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_full got ready=%0b want 0", mem_ready);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        wb_stall = 1'b0;
        query_a = 5'd4;
        #1;
        exp_ret = 0;
        checks++;
        if (mem_ready !== 1'b1 || writeback_rd_we !== 1'b0 || writeback_rd_a !== 5'd0 ||
            retired !== exp_ret || query_hit !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got rdy=%0b we=%0b a=%0d ret=%0d hit=%0b want 1 0 0 0 0",
                     mem_ready, writeback_rd_we, writeback_rd_a, retired, query_hit);
        end
        tick();
        checks++;
        if (writeback_rd_we !== 1'b0 || retired !== 32'd0) begin
            failures++;
            $display("FAIL mid_after got we=%0b ret=%0d want 0 0", writeback_rd_we, retired);
        end
    endtask

    initial begin
        rst = 1'b0; mem_valid = 1'b0; mem_rd_we = 1'b0; mem_rd_a = '0;
        mem_is_load = 1'b0; mem_funct3 = '0; mem_result = '0; mem_load_word = '0;
        wb_stall = 1'b0; query_a = '0;
        test_reset();
        test_alu();
        test_loads();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_x0();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
